// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes and FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } mem_size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// RAM-side request/response bus of the memory access unit.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                MemReq;
    logic                MemWe;
    logic [ADDR_W-1:0]   MemAddr;
    logic [DATA_W/8-1:0] MemBe;
    logic [DATA_W-1:0]   MemWData;
    logic [DATA_W-1:0]   MemRData;
    logic                MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemBe, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemBe, MemWData,
        output MemRData, MemAck
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication, byte enables,
// load extraction with sign/zero extension, and alignment check.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  logic [LANE_W-1:0]   lane_i,
    input  mem_size_e           size_i,
    input  logic                uns_i,
    input  logic [DATA_W-1:0]   st_val_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] be_o,
    output logic [DATA_W-1:0]   ld_val_o,
    output logic                misalign_o
);
    localparam int NB = DATA_W/8;

    logic [DATA_W-1:0] shifted;
    logic              fill;
    int                nbytes;
    int                nbits;

    always_comb begin
        misalign_o = 1'b0;
        case (size_i)
            SZ_HALF:  misalign_o = lane_i[0];
            SZ_WORD:  misalign_o = |lane_i[1:0];
            SZ_DWORD: misalign_o = (DATA_W == 32) || (|lane_i);
            default:  misalign_o = 1'b0;
        endcase
    end

    // Store data is the low bytes of the value repeated across every lane
    always_comb begin
        nbytes  = 1 << int'(size_i);
        wdata_o = '0;
        be_o    = '0;
        for (int i = 0; i < NB; i++) begin
            be_o[i] = (i >= int'(lane_i)) && (i < int'(lane_i) + nbytes);
            case (size_i)
                SZ_BYTE: wdata_o[8*i +: 8] = st_val_i[7:0];
                SZ_HALF: wdata_o[8*i +: 8] = st_val_i[8*(i%2) +: 8];
                SZ_WORD: wdata_o[8*i +: 8] = st_val_i[8*(i%4) +: 8];
                default: wdata_o[8*i +: 8] = st_val_i[8*i +: 8];
            endcase
        end
    end

    always_comb begin
        shifted = rdata_i >> {lane_i, 3'b000};
        nbits   = 8 << int'(size_i);
        case (size_i)
            SZ_BYTE: fill = ~uns_i & shifted[7];
            SZ_HALF: fill = ~uns_i & shifted[15];
            SZ_WORD: fill = ~uns_i & shifted[31];
            default: fill = ~uns_i & shifted[DATA_W-1];
        endcase
        ld_val_o = '0;
        for (int b = 0; b < DATA_W; b++)
            ld_val_o[b] = (b < nbits) ? shifted[b] : fill;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues one RAM access per load/store, stalls upstream until
// MemAck or timeout, and registers the write-back result.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [ADDR_W-1:0]  ExResult,
    input  logic [DATA_W-1:0]  ExStoreVal,
    input  logic [REG_W-1:0]   ExDstIn,
    input  logic               ExWbIn,
    input  logic               isMemRead,
    input  logic               isMemWrite,
    input  logic [1:0]         MemSize,
    input  logic               MemUnsigned,
    mem_access_unit_if.master  mem,
    output logic               Stall,
    output logic [DATA_W-1:0]  Result_or_MemVal,
    output logic [REG_W-1:0]   MemDstOut,
    output logic               MemWbOut,
    output logic               AlignErr,
    output logic               BusErr
);
    localparam int NB     = DATA_W/8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = 8;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    mem_size_e           size_q, size_d;
    logic                uns_q, uns_d, ld_q, ld_d, wb_q, wb_d;
    logic [REG_W-1:0]    dst_q, dst_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [REG_W-1:0]    dout_q, dout_d;
    logic                wbout_q, wbout_d, aerr_q, aerr_d, berr_q, berr_d;
    logic                stall_c;

    logic                in_idle, is_mem, timeout, misalign;
    logic [LANE_W-1:0]   al_lane;
    mem_size_e           al_size;
    logic                al_uns;
    logic [NB-1:0]       al_be;
    logic [DATA_W-1:0]   al_wdata, al_ld;

    assign in_idle = (state_q == S_IDLE);
    assign is_mem  = isMemRead | isMemWrite;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT-1));

    // IDLE steers the new request; REQ extracts the load with latched lane info
    assign al_lane = in_idle ? ExResult[LANE_W-1:0] : lane_q;
    assign al_size = in_idle ? mem_size_e'(MemSize) : size_q;
    assign al_uns  = in_idle ? MemUnsigned : uns_q;

    mem_lane_align #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_align (
        .lane_i     (al_lane),
        .size_i     (al_size),
        .uns_i      (al_uns),
        .st_val_i   (ExStoreVal),
        .rdata_i    (mem.MemRData),
        .wdata_o    (al_wdata),
        .be_o       (al_be),
        .ld_val_o   (al_ld),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d = state_q;  cnt_d   = cnt_q;
        req_d   = req_q;    we_d    = we_q;
        addr_d  = addr_q;   be_d    = be_q;    wdata_d = wdata_q;
        lane_d  = lane_q;   size_d  = size_q;  uns_d   = uns_q;
        ld_d    = ld_q;     dst_d   = dst_q;   wb_d    = wb_q;
        res_d   = res_q;    dout_d  = dout_q;  wbout_d = wbout_q;
        aerr_d  = 1'b0;     berr_d  = 1'b0;    stall_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mem && misalign) begin
                    aerr_d  = 1'b1;
                    wbout_d = 1'b0;
                end else if (is_mem) begin
                    stall_c = 1'b1;
                    state_d = S_REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = isMemWrite;
                    addr_d  = {ExResult[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    lane_d  = ExResult[LANE_W-1:0];
                    size_d  = mem_size_e'(MemSize);
                    uns_d   = MemUnsigned;
                    ld_d    = ~isMemWrite;
                    dst_d   = ExDstIn;
                    wb_d    = ExWbIn;
                end else begin
                    res_d   = DATA_W'(ExResult);
                    dout_d  = ExDstIn;
                    wbout_d = ExWbIn;
                end
            end
            S_REQ: begin
                // An ack arriving on the timeout cycle still completes normally
                if (mem.MemAck) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    res_d   = ld_q ? al_ld : DATA_W'(ExResult);
                    dout_d  = dst_q;
                    wbout_d = wb_q;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    berr_d  = 1'b1;
                    wbout_d = 1'b0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;  cnt_q  <= '0;
            req_q   <= 1'b0;    we_q   <= 1'b0;
            addr_q  <= '0;      be_q   <= '0;     wdata_q <= '0;
            lane_q  <= '0;      size_q <= SZ_BYTE; uns_q  <= 1'b0;
            ld_q    <= 1'b0;    dst_q  <= '0;     wb_q    <= 1'b0;
            res_q   <= '0;      dout_q <= '0;     wbout_q <= 1'b0;
            aerr_q  <= 1'b0;    berr_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q  <= cnt_d;
            req_q   <= req_d;   we_q   <= we_d;
            addr_q  <= addr_d;  be_q   <= be_d;   wdata_q <= wdata_d;
            lane_q  <= lane_d;  size_q <= size_d; uns_q   <= uns_d;
            ld_q    <= ld_d;    dst_q  <= dst_d;  wb_q    <= wb_d;
            res_q   <= res_d;   dout_q <= dout_d; wbout_q <= wbout_d;
            aerr_q  <= aerr_d;  berr_q <= berr_d;
        end
    end

    assign mem.MemReq       = req_q;
    assign mem.MemWe        = we_q;
    assign mem.MemAddr      = addr_q;
    assign mem.MemBe        = be_q;
    assign mem.MemWData     = wdata_q;
    assign Stall            = stall_c & Reset_n;
    assign Result_or_MemVal = res_q;
    assign MemDstOut        = dout_q;
    assign MemWbOut         = wbout_q;
    assign AlignErr         = aerr_q;
    assign BusErr           = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus timeout/reset sequences.
module tb_mem_access_unit;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] ExResult, ExStoreVal;
    logic [4:0]  ExDstIn;
    logic        ExWbIn, isMemRead, isMemWrite, MemUnsigned;
    logic [1:0]  MemSize;
    logic        Stall, MemWbOut, AlignErr, BusErr;
    logic [31:0] Result_or_MemVal;
    logic [4:0]  MemDstOut;
    int          checks = 0;
    int          failures = 0;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) mif ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ExResult(ExResult), .ExStoreVal(ExStoreVal),
        .ExDstIn(ExDstIn), .ExWbIn(ExWbIn), .isMemRead(isMemRead), .isMemWrite(isMemWrite),
        .MemSize(MemSize), .MemUnsigned(MemUnsigned), .mem(mif), .Stall(Stall),
        .Result_or_MemVal(Result_or_MemVal), .MemDstOut(MemDstOut), .MemWbOut(MemWbOut),
        .AlignErr(AlignErr), .BusErr(BusErr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, sval, rdata;
        logic [4:0]  dst;
        logic        wb;
        int          ack_cyc;
        logic        align;
        logic [31:0] exp_res, exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mkv(logic rd, logic wr, logic [1:0] size, logic uns,
                                 logic [31:0] addr, logic [31:0] sval, logic [31:0] rdata,
                                 logic [4:0] dst, logic wb, int ack_cyc, logic align,
                                 logic [31:0] exp_res, logic [31:0] exp_addr,
                                 logic [3:0] exp_be, logic [31:0] exp_wdata, logic exp_wb);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.sval = sval;
        v.rdata = rdata; v.dst = dst; v.wb = wb; v.ack_cyc = ack_cyc; v.align = align;
        v.exp_res = exp_res; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_wb = exp_wb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ExResult = v.addr; ExStoreVal = v.sval; ExDstIn = v.dst; ExWbIn = v.wb;
        isMemRead = v.rd; isMemWrite = v.wr; MemSize = v.size; MemUnsigned = v.uns;
        mif.MemRData = v.rdata; mif.MemAck = 1'b0;
    endtask

    task automatic idle_inputs();
        isMemRead = 1'b0; isMemWrite = 1'b0; ExWbIn = 1'b0; ExResult = '0; ExDstIn = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int stalls;
        drive(v);
        #1;
        if (!(v.rd | v.wr) || v.align) begin
            chk($sformatf("v%0d_stall", idx), Stall, 1'b0);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_alignerr", idx), AlignErr, v.align);
            chk($sformatf("v%0d_noreq", idx), mif.MemReq, 1'b0);
        end else begin
            chk($sformatf("v%0d_stall_idle", idx), Stall, 1'b1);
            stalls = 1;
            @(posedge Clk); #1;
            chk($sformatf("v%0d_memreq", idx), mif.MemReq, 1'b1);
            chk($sformatf("v%0d_memwe", idx), mif.MemWe, v.wr);
            chk($sformatf("v%0d_addr", idx), mif.MemAddr, v.exp_addr);
            chk($sformatf("v%0d_be", idx), mif.MemBe, v.exp_be);
            if (v.wr) chk($sformatf("v%0d_wdata", idx), mif.MemWData, v.exp_wdata);
            for (int c = 1; c <= v.ack_cyc; c++) begin
                mif.MemAck = (c == v.ack_cyc);
                #1;
                if (Stall) stalls++;
                @(posedge Clk); #1;
            end
            mif.MemAck = 1'b0;
            chk($sformatf("v%0d_stalls", idx), stalls, v.ack_cyc);
            chk($sformatf("v%0d_req_drop", idx), mif.MemReq, 1'b0);
        end
        if (!v.align) begin
            chk($sformatf("v%0d_result", idx), Result_or_MemVal, v.exp_res);
            chk($sformatf("v%0d_dst", idx), MemDstOut, v.dst);
        end
        chk($sformatf("v%0d_wb", idx), MemWbOut, v.exp_wb);
    endtask

    initial begin
        int reqc;
        bit seen_bus, bad;
        //                rd wr sz  uns addr          sval          rdata         dst wb ack al exp_res       exp_addr      be     wdata         wb
        tbl[0]  = mkv(0, 0, 2'd0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        5,  1, 0, 0, 32'hDEADBEEF, 32'h0,        4'h0, 32'h0,        1);
        tbl[1]  = mkv(1, 0, 2'd2, 0, 32'h100,      32'h0,        32'h8899AABB, 3,  1, 1, 0, 32'h8899AABB, 32'h100,      4'hF, 32'h0,        1);
        tbl[2]  = mkv(1, 0, 2'd0, 0, 32'h103,      32'h0,        32'h80112233, 4,  1, 1, 0, 32'hFFFFFF80, 32'h100,      4'h8, 32'h0,        1);
        tbl[3]  = mkv(1, 0, 2'd0, 1, 32'h103,      32'h0,        32'h80112233, 4,  1, 1, 0, 32'h00000080, 32'h100,      4'h8, 32'h0,        1);
        tbl[4]  = mkv(0, 1, 2'd1, 0, 32'h102,      32'h1234,     32'h0,        0,  0, 1, 0, 32'h102,      32'h100,      4'hC, 32'h12341234, 0);
        tbl[5]  = mkv(1, 0, 2'd1, 0, 32'h102,      32'h0,        32'h80112233, 6,  1, 3, 0, 32'hFFFF8011, 32'h100,      4'hC, 32'h0,        1);
        tbl[6]  = mkv(1, 0, 2'd1, 1, 32'h100,      32'h0,        32'h80119234, 7,  1, 2, 0, 32'h00009234, 32'h100,      4'h3, 32'h0,        1);
        tbl[7]  = mkv(0, 1, 2'd0, 0, 32'h101,      32'hABCDEF12, 32'h0,        0,  0, 1, 0, 32'h101,      32'h100,      4'h2, 32'h12121212, 0);
        tbl[8]  = mkv(0, 1, 2'd2, 0, 32'h200,      32'hCAFEF00D, 32'h0,        2,  0, 2, 0, 32'h200,      32'h200,      4'hF, 32'hCAFEF00D, 0);
        tbl[9]  = mkv(1, 1, 2'd2, 0, 32'h300,      32'h11223344, 32'hDEADDEAD, 8,  1, 1, 0, 32'h300,      32'h300,      4'hF, 32'h11223344, 1);
        tbl[10] = mkv(1, 0, 2'd2, 0, 32'h101,      32'h0,        32'h0,        9,  1, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0);
        tbl[11] = mkv(1, 0, 2'd1, 0, 32'h103,      32'h0,        32'h0,        9,  1, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0);
        tbl[12] = mkv(1, 0, 2'd3, 0, 32'h100,      32'h0,        32'h0,        9,  1, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        0);
        tbl[13] = mkv(1, 0, 2'd0, 0, 32'h101,      32'h0,        32'h00007F00, 10, 1, 1, 0, 32'h0000007F, 32'h100,      4'h2, 32'h0,        1);

        Reset_n = 1'b0;
        idle_inputs();
        ExStoreVal = '0; MemSize = '0; MemUnsigned = 1'b0;
        mif.MemRData = '0; mif.MemAck = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_memreq", mif.MemReq, 1'b0);
        chk("rst_memwe", mif.MemWe, 1'b0);
        chk("rst_membe", mif.MemBe, 4'h0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_wbout", MemWbOut, 1'b0);
        chk("rst_alignerr", AlignErr, 1'b0);
        chk("rst_buserr", BusErr, 1'b0);
        chk("rst_result", Result_or_MemVal, 32'h0);
        chk("rst_dst", MemDstOut, 5'h0);
        #3 Reset_n = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

        // AlignErr lasts exactly one cycle
        idle_inputs();
        @(posedge Clk); #1;
        chk("align_pulse_end", AlignErr, 1'b0);

        // MemAck in IDLE must not start or complete anything
        ExResult = 32'h55; ExDstIn = 5'd1; ExWbIn = 1'b1; mif.MemAck = 1'b1;
        @(posedge Clk); #1;
        mif.MemAck = 1'b0;
        chk("idle_ack_noreq", mif.MemReq, 1'b0);
        chk("idle_ack_result", Result_or_MemVal, 32'h55);

        // Ack on the last allowed cycle wins over timeout
        isMemRead = 1'b1; MemSize = 2'd2; MemUnsigned = 1'b0;
        ExResult = 32'h404; ExDstIn = 5'd12; ExWbIn = 1'b1; mif.MemRData = 32'h55AA55AA;
        @(posedge Clk); #1;
        for (int c = 1; c <= 15; c++) begin
            mif.MemAck = (c == 15);
            @(posedge Clk); #1;
        end
        mif.MemAck = 1'b0;
        chk("ackto_buserr", BusErr, 1'b0);
        chk("ackto_result", Result_or_MemVal, 32'h55AA55AA);
        chk("ackto_wb", MemWbOut, 1'b1);
        chk("ackto_req_drop", mif.MemReq, 1'b0);

        // No ack at all: 15 REQ cycles then a bus error
        ExResult = 32'h408; ExDstIn = 5'd13;
        @(posedge Clk); #1;
        reqc = 0; seen_bus = 0;
        for (int c = 0; c < 40 && !seen_bus; c++) begin
            if (mif.MemReq) reqc++;
            if (mif.MemReq && reqc == 15) chk("to_last_stall", Stall, 1'b0);
            @(posedge Clk); #1;
            if (BusErr) seen_bus = 1;
        end
        chk("to_req_cycles", reqc, 15);
        chk("to_buserr", seen_bus, 1'b1);
        chk("to_req_drop", mif.MemReq, 1'b0);
        chk("to_wb", MemWbOut, 1'b0);
        idle_inputs();
        @(posedge Clk); #1;
        chk("to_buserr_pulse_end", BusErr, 1'b0);
        chk("to_idle_noreq", mif.MemReq, 1'b0);

        // Reset in REQ cycle 3 aborts the access for good
        isMemRead = 1'b1; MemSize = 2'd2; ExResult = 32'h500; ExDstIn = 5'd9; ExWbIn = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("rstreq_req_before", mif.MemReq, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk("rstreq_req_async", mif.MemReq, 1'b0);
        idle_inputs();
        @(posedge Clk); #3;
        Reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            mif.MemAck = c[0];
            @(posedge Clk); #1;
            if (BusErr || MemWbOut || mif.MemReq) bad = 1;
        end
        mif.MemAck = 1'b0;
        chk("rstreq_no_activity", bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
